spi_file_mem_frontend: RTL and testbench

Serial-flash front end that sits directly upstream of the plusarg file-backed memory model and feeds its `mem_req_*` port. It decodes SPI mode-0 flash commands, oversampled on the system clock, into single-byte memory reads and writes. It returns read data on MISO, so a chip under test can boot from a simulated SPI flash whose contents come from a plusarg file.

---
 rtl/spi_file_mem_frontend.sv | 193 +++++++++++++++++++
 tb/tb_spi_file_mem_frontend.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_file_mem_frontend.sv
// SPI mode-0 flash slave, oversampled on clock, turning READ/FAST_READ/PROGRAM
// commands into single-byte requests for the file-backed memory model.
//   state  | meaning
//   IDLE   | cs_n high; waits for select, clears counters
//   CMD    | shifting in the 8-bit opcode
//   ADDR   | shifting in the 24-bit address
//   DUMMY  | FAST_READ: 8 dummy sck cycles
//   RDATA  | streaming read bytes out on miso
//   WDATA  | collecting write bytes
//   IGNORE | unknown opcode; idle until deselect
module spi_file_mem_frontend #(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 spi_sck,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic                 mem_req_valid,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [DATA_BITS-1:0] mem_req_data,
    output logic                 mem_req_r_wb,
    input  logic [DATA_BITS-1:0] mem_resp_data
);

    if (DATA_BITS != 8) begin : g_data_chk
        $error("spi_file_mem_frontend: DATA_BITS must be 8");
    end
    if (ADDR_BITS < 8 || ADDR_BITS > 32) begin : g_addr_chk
        $error("spi_file_mem_frontend: ADDR_BITS must be in 8..32");
    end

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DUMMY  = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_WDATA  = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    logic [1:0] sck_sync, cs_sync, mosi_sync;
    logic       sck_prev;
    logic       sck_rise, sck_fall, cs_high, mosi_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_sck};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_prev  <= sck_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign sck_fall = ~sck_sync[1] & sck_prev;
    assign cs_high  = cs_sync[1];
    assign mosi_s   = mosi_sync[1];

    logic [2:0]           state_q, after_q;
    logic [4:0]           bitcnt_q;
    logic [DATA_BITS-1:0] sr_q, shift_q, next_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 resp_due_q, first_q, load_next_q;

    logic [DATA_BITS-1:0] sr_nxt;
    logic [ADDR_BITS-1:0] addr_shift, addr_inc;

    assign sr_nxt     = {sr_q[DATA_BITS-2:0], mosi_s};
    assign addr_shift = {addr_q[ADDR_BITS-2:0], mosi_s};
    assign addr_inc   = addr_q + ADDR_BITS'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            after_q       <= S_IGNORE;
            bitcnt_q      <= '0;
            sr_q          <= '0;
            shift_q       <= '0;
            next_q        <= '0;
            addr_q        <= '0;
            resp_due_q    <= 1'b0;
            first_q       <= 1'b0;
            load_next_q   <= 1'b0;
            spi_miso      <= 1'b0;
            spi_miso_oe   <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_r_wb  <= 1'b1;
        end else begin
            mem_req_valid <= 1'b0;
            mem_req_r_wb  <= 1'b1;
            resp_due_q    <= mem_req_valid & mem_req_r_wb;
            load_next_q   <= 1'b0;
            // Deselect overrides everything, including an sck edge seen the same cycle.
            if (cs_high) begin
                state_q     <= S_IDLE;
                spi_miso_oe <= 1'b0;
                resp_due_q  <= 1'b0;
            end else begin
                if (resp_due_q && state_q == S_RDATA) begin
                    if (first_q) begin
                        shift_q <= mem_resp_data;
                    end else begin
                        next_q      <= mem_resp_data;
                        load_next_q <= 1'b1;
                    end
                    first_q <= 1'b0;
                end
                if (load_next_q) shift_q <= next_q;

                case (state_q)
                    S_IDLE: begin
                        state_q  <= S_CMD;
                        bitcnt_q <= '0;
                        addr_q   <= '0;
                    end
                    S_CMD: if (sck_rise) begin
                        sr_q     <= sr_nxt;
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_q <= '0;
                            state_q  <= S_ADDR;
                            case (sr_nxt)
                                8'h03:   after_q <= S_RDATA;
                                8'h0B:   after_q <= S_DUMMY;
                                8'h02:   after_q <= S_WDATA;
                                default: state_q <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR: if (sck_rise) begin
                        addr_q   <= addr_shift;
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd23) begin
                            bitcnt_q <= '0;
                            state_q  <= after_q;
                            if (after_q == S_RDATA) begin
                                mem_req_valid <= 1'b1;
                                mem_req_addr  <= addr_shift;
                                first_q       <= 1'b1;
                            end
                        end
                    end
                    S_DUMMY: if (sck_rise) begin
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_q      <= '0;
                            state_q       <= S_RDATA;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= addr_q;
                            first_q       <= 1'b1;
                        end
                    end
                    S_RDATA: if (sck_fall) begin
                        spi_miso    <= shift_q[3'd7 - bitcnt_q[2:0]];
                        spi_miso_oe <= 1'b1;
                        bitcnt_q    <= bitcnt_q + 5'd1;
                        // Last bit of the byte is out: prefetch the next address.
                        if (bitcnt_q[2:0] == 3'd7) begin
                            bitcnt_q      <= '0;
                            addr_q        <= addr_inc;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= addr_inc;
                        end
                    end
                    S_WDATA: if (sck_rise) begin
                        sr_q     <= sr_nxt;
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_q      <= '0;
                            mem_req_valid <= 1'b1;
                            mem_req_r_wb  <= 1'b0;
                            mem_req_addr  <= addr_q;
                            mem_req_data  <= sr_nxt;
                            addr_q        <= addr_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_file_mem_frontend.sv
// Directed plus randomized bench for spi_file_mem_frontend against a
// byte-array flash model and transaction-level expectations.
module tb_spi_file_mem_frontend;
    localparam int H = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;
    logic        mem_req_valid, mem_req_r_wb;
    logic [23:0] mem_req_addr;
    logic [7:0]  mem_req_data;
    logic [7:0]  mem_resp_data = 8'h00;

    always #5 clock = ~clock;

    spi_file_mem_frontend #(.ADDR_BITS(24), .DATA_BITS(8)) dut (
        .clock(clock), .reset(reset),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_r_wb(mem_req_r_wb),
        .mem_resp_data(mem_resp_data)
    );

    logic [7:0]  mem [int unsigned];
    int unsigned req_addr_q[$];
    logic        req_rw_q[$];
    logic [7:0]  req_data_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          rwb_bad = 0;
    int          oe_bad = 0;
    bit          watch_no_oe = 1'b0;
    bit          pend = 1'b0;
    int unsigned pend_addr = 0;

    function automatic logic [7:0] rd_mem(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return 8'(a ^ (a >> 8) ^ 32'h5A);
    endfunction

    // Flash model: read data is presented only during the cycle after the request.
    always @(negedge clock) begin
        mem_resp_data = pend ? rd_mem(pend_addr) : 8'($urandom);
        pend = 1'b0;
        if (reset && mem_req_valid) begin
            req_addr_q.push_back(32'(mem_req_addr));
            req_rw_q.push_back(mem_req_r_wb);
            req_data_q.push_back(mem_req_data);
            if (mem_req_r_wb) begin
                pend = 1'b1;
                pend_addr = 32'(mem_req_addr);
            end else begin
                mem[32'(mem_req_addr)] = mem_req_data;
            end
        end
        if (!mem_req_valid && !mem_req_r_wb) rwb_bad++;
        if (watch_no_oe && spi_miso_oe) oe_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic mo, output logic mi, output logic oe);
        spi_mosi = mo;
        repeat (H) @(negedge clock);
        mi = spi_miso;
        oe = spi_miso_oe;
        spi_sck = 1'b1;
        repeat (H) @(negedge clock);
        spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic mi, oe;
        for (int i = 7; i >= 0; i--) spi_bit(b[i], mi, oe);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic oe_low);
        logic mi, oe;
        oe_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(1'($urandom_range(1)), mi, oe);
            b[i] = mi;
            if (!oe) oe_low = 1'b1;
        end
    endtask

    task automatic cs_begin();
        req_addr_q.delete();
        req_rw_q.delete();
        req_data_q.delete();
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clock);
    endtask

    task automatic cs_end();
        repeat (H) @(negedge clock);
        spi_cs_n = 1'b1;
        repeat (2 * H) @(negedge clock);
    endtask

    task automatic do_read(input logic [23:0] a, input int n, input bit fast);
        logic [7:0]  b;
        logic        oe_low, mi, oe;
        int          oe_before;
        int unsigned ea;
        oe_before = oe_bad;
        cs_begin();
        watch_no_oe = 1'b1;
        send_byte(fast ? 8'h0B : 8'h03);
        send_addr(a);
        if (fast) for (int i = 0; i < 8; i++) spi_bit(1'($urandom_range(1)), mi, oe);
        watch_no_oe = 1'b0;
        check(fast ? "fr_pre_oe" : "rd_pre_oe", 32'(oe_bad - oe_before), 0);
        for (int i = 0; i < n; i++) begin
            recv_byte(b, oe_low);
            ea = (32'(a) + 32'(i)) & 32'h00FF_FFFF;
            check(fast ? "fr_byte" : "rd_byte", 32'(b), 32'(rd_mem(ea)));
            check("rd_oe_low", 32'(oe_low), 0);
        end
        cs_end();
        check("rd_nreq", 32'(req_addr_q.size()), 32'(n + 1));
        for (int i = 0; i < req_addr_q.size(); i++) begin
            ea = (32'(a) + 32'(i)) & 32'h00FF_FFFF;
            check("rd_addr", req_addr_q[i], ea);
            check("rd_rwb", 32'(req_rw_q[i]), 1);
        end
    endtask

    task automatic do_prog(input logic [23:0] a, input logic [7:0] d[$], input int extra);
        logic        mi, oe;
        int unsigned ea;
        cs_begin();
        watch_no_oe = 1'b1;
        send_byte(8'h02);
        send_addr(a);
        foreach (d[i]) send_byte(d[i]);
        for (int i = 0; i < extra; i++) spi_bit(1'($urandom_range(1)), mi, oe);
        cs_end();
        watch_no_oe = 1'b0;
        check("wr_nreq", 32'(req_addr_q.size()), 32'(d.size()));
        for (int i = 0; i < req_addr_q.size() && i < d.size(); i++) begin
            ea = (32'(a) + 32'(i)) & 32'h00FF_FFFF;
            check("wr_addr", req_addr_q[i], ea);
            check("wr_rwb", 32'(req_rw_q[i]), 0);
            check("wr_data", 32'(req_data_q[i]), 32'(d[i]));
        end
    endtask

    initial begin
        logic [7:0]  wd[$];
        logic [7:0]  rb;
        logic        mi, oe, oe_low;
        logic [23:0] ra;
        int          n;

        repeat (4) @(negedge clock);
        check("rst_miso", 32'(spi_miso), 0);
        check("rst_oe", 32'(spi_miso_oe), 0);
        check("rst_valid", 32'(mem_req_valid), 0);
        check("rst_addr", 32'(mem_req_addr), 0);
        check("rst_data", 32'(mem_req_data), 0);
        check("rst_rwb", 32'(mem_req_r_wb), 1);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        mem[32'h100] = 8'hA5;
        mem[32'h101] = 8'h3C;
        do_read(24'h000100, 2, 1'b0);

        mem[32'h10] = 8'h81;
        do_read(24'h000010, 1, 1'b1);

        mem[32'hFFFFFF] = 8'h5E;
        mem[32'h0] = 8'hC7;
        do_read(24'hFFFFFF, 2, 1'b0);

        wd = '{8'h11, 8'h22};
        do_prog(24'h000020, wd, 3);
        do_read(24'h000020, 2, 1'b0);

        // Unsupported opcode: no traffic and no drive, then a normal read.
        cs_begin();
        watch_no_oe = 1'b1;
        n = oe_bad;
        send_byte(8'h9F);
        for (int i = 0; i < 32; i++) spi_bit(1'($urandom_range(1)), mi, oe);
        cs_end();
        watch_no_oe = 1'b0;
        check("ign_nreq", 32'(req_addr_q.size()), 0);
        check("ign_oe", 32'(oe_bad - n), 0);
        do_read(24'h000100, 1, 1'b0);

        for (int t = 0; t < 4; t++) begin
            ra = 24'($urandom);
            n = int'($urandom_range(1, 3));
            for (int i = 0; i <= n; i++) mem[(32'(ra) + 32'(i)) & 32'h00FF_FFFF] = 8'($urandom);
            do_read(ra, n, 1'($urandom_range(1)));
        end
        for (int t = 0; t < 2; t++) begin
            ra = 24'($urandom);
            wd.delete();
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) wd.push_back(8'($urandom));
            do_prog(ra, wd, int'($urandom_range(0, 7)));
            do_read(ra, n, 1'b0);
        end

        // Reset in the middle of the read data phase takes effect without a clock edge.
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000100);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, mi, oe);
        check("pre_rst_oe", 32'(spi_miso_oe), 1);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("arst_oe", 32'(spi_miso_oe), 0);
        check("arst_valid", 32'(mem_req_valid), 0);
        check("arst_miso", 32'(spi_miso), 0);
        check("arst_rwb", 32'(mem_req_r_wb), 1);
        spi_cs_n = 1'b1;
        spi_sck = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        do_read(24'h000100, 2, 1'b0);

        check("rwb_idle", 32'(rwb_bad), 0);
        check("oe_quiet", 32'(oe_bad), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
